// File: rtl/rv_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter between the RISC-V core and the DMA/loader.
package rv_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DMA  = 1'b1
    } req_id_t;

    localparam int RD_LAT_MAX = 15;
    localparam int CNT_W      = $clog2(RD_LAT_MAX + 1);

endpackage

// File: rtl/rv_mem_arb_if.sv
// Requester handshakes plus the single memory port; master is the arbiter side, slave the requesters/memory.
interface rv_mem_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_gnt;
    logic              c_done;
    logic [DATA_W-1:0] c_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              core_stall;

    modport master (
        input  c_req, c_we, c_addr, c_wdata,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata,
        output c_gnt, c_done, c_rdata,
        output d_gnt, d_done, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output core_stall
    );

    modport slave (
        output c_req, c_we, c_addr, c_wdata,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata,
        input  c_gnt, c_done, c_rdata,
        input  d_gnt, d_done, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  core_stall
    );

endinterface

// File: rtl/rv_rr_pick.sv
// Two-way round-robin picker: on a tie the requester that was not served last wins.
module rv_rr_pick
    import rv_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last,
    output logic       valid,
    output req_id_t    pick
);

    always_comb begin
        valid = |req;
        pick  = REQ_CORE;
        if (req == 2'b11) begin
            pick = (last == REQ_CORE) ? REQ_DMA : REQ_CORE;
        end else if (req[1]) begin
            pick = REQ_DMA;
        end
    end

endmodule

// File: rtl/rv_mem_arb.sv
// Round-robin sequencer for the shared single-port memory: latches one request, strobes the port,
// waits out the fixed read latency and returns data with a done pulse.
module rv_mem_arb
    import rv_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input logic           clk,
    input logic           rst,
    rv_mem_arb_if.master  bus
);

    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    arb_state_t        state;
    arb_state_t        state_nxt;
    req_id_t           last;
    req_id_t           own;
    req_id_t           pick;
    logic              pick_valid;
    logic              t_we;
    logic [ADDR_W-1:0] t_addr;
    logic [DATA_W-1:0] t_wdata;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] c_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    rv_rr_pick u_pick (
        .req   ({bus.d_req, bus.c_req}),
        .last  (last),
        .valid (pick_valid),
        .pick  (pick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_valid) state_nxt = ACCESS;
            ACCESS:  state_nxt = t_we ? DONE : WAIT;
            WAIT:    if (cnt == CNT_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Requests are only looked at in IDLE; the transaction registers then own the memory port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last      <= REQ_DMA;
            own       <= REQ_CORE;
            t_we      <= 1'b0;
            t_addr    <= '0;
            t_wdata   <= '0;
            cnt       <= '0;
            c_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        own <= pick;
                        if (pick == REQ_DMA) begin
                            t_we    <= bus.d_we;
                            t_addr  <= bus.d_addr;
                            t_wdata <= bus.d_wdata;
                        end else begin
                            t_we    <= bus.c_we;
                            t_addr  <= bus.c_addr;
                            t_wdata <= bus.c_wdata;
                        end
                    end
                end
                ACCESS: begin
                    last <= own;
                    if (!t_we) cnt <= LAT_INIT;
                end
                WAIT: begin
                    cnt <= cnt - CNT_LAST;
                    if (cnt == CNT_LAST) begin
                        if (own == REQ_CORE) c_rdata_q <= bus.mem_rdata;
                        else                 d_rdata_q <= bus.mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_en    = (state == ACCESS);
    assign bus.mem_we    = (state == ACCESS) && t_we;
    assign bus.mem_addr  = t_addr;
    assign bus.mem_wdata = t_wdata;

    assign bus.c_gnt   = (state == ACCESS) && (own == REQ_CORE);
    assign bus.d_gnt   = (state == ACCESS) && (own == REQ_DMA);
    assign bus.c_done  = (state == DONE) && (own == REQ_CORE);
    assign bus.d_done  = (state == DONE) && (own == REQ_DMA);
    assign bus.c_rdata = c_rdata_q;
    assign bus.d_rdata = d_rdata_q;

    // Stall drops in the core's DONE cycle so the core FSM can consume c_done immediately.
    assign bus.core_stall = bus.c_req ||
                            ((own == REQ_CORE) && ((state == ACCESS) || (state == WAIT)));

endmodule

// File: tb/tb_rv_mem_arb.sv
// Self-checking bench for rv_mem_arb: four instances (RD_LAT 2,1,3,15) with per-lane memory models,
// directed handshake scenarios plus random transactions checked against a shadow memory.
module tb_rv_mem_arb;
    import rv_arb_pkg::*;

    localparam int NL = 4;

    function automatic int latOf(int l);
        case (l)
            0:       return 2;
            1:       return 1;
            2:       return 3;
            default: return 15;
        endcase
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NL-1:0] c_req = '0, c_we = '0, d_req = '0, d_we = '0;
    logic [31:0]   c_addr [NL];
    logic [31:0]   c_wdata [NL];
    logic [31:0]   d_addr [NL];
    logic [31:0]   d_wdata [NL];

    logic [NL-1:0] c_gnt_v, c_done_v, d_gnt_v, d_done_v, mem_en_v, mem_we_v, stall_v;
    logic [31:0]   mem_addr_v [NL];
    logic [31:0]   mem_wdata_v [NL];
    logic [31:0]   c_rdata_v [NL];
    logic [31:0]   d_rdata_v [NL];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [31:0] shadow [bit [33:0]];

    for (genvar g = 0; g < NL; g++) begin : lane
        localparam int LAT = latOf(g);

        rv_mem_arb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

        assign bus.c_req   = c_req[g];
        assign bus.c_we    = c_we[g];
        assign bus.c_addr  = c_addr[g];
        assign bus.c_wdata = c_wdata[g];
        assign bus.d_req   = d_req[g];
        assign bus.d_we    = d_we[g];
        assign bus.d_addr  = d_addr[g];
        assign bus.d_wdata = d_wdata[g];

        assign c_gnt_v[g]     = bus.c_gnt;
        assign c_done_v[g]    = bus.c_done;
        assign d_gnt_v[g]     = bus.d_gnt;
        assign d_done_v[g]    = bus.d_done;
        assign mem_en_v[g]    = bus.mem_en;
        assign mem_we_v[g]    = bus.mem_we;
        assign stall_v[g]     = bus.core_stall;
        assign mem_addr_v[g]  = bus.mem_addr;
        assign mem_wdata_v[g] = bus.mem_wdata;
        assign c_rdata_v[g]   = bus.c_rdata;
        assign d_rdata_v[g]   = bus.d_rdata;

        rv_mem_arb #(.ADDR_W(32), .DATA_W(32), .RD_LAT(LAT)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        // Memory model: read data appears only in the cycle LAT after the strobe, 0xBAD otherwise.
        logic [31:0] mem [bit [31:0]];
        logic [31:0] rd;
        logic [31:0] raddr;
        int          left;
        assign bus.mem_rdata = rd;
        initial mem[32'h40] = 32'hDEADBEEF;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                left = 0;
                rd <= 32'hBAD;
            end else begin
                if (bus.mem_en) begin
                    if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
                    else begin
                        left  = LAT;
                        raddr = bus.mem_addr;
                    end
                end
                if (left == 1) rd <= mem.exists(raddr) ? mem[raddr] : 32'h0;
                else           rd <= 32'hBAD;
                if (left > 0) left = left - 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic checkOutput(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(int l, bit cr, bit cw, logic [31:0] ca, logic [31:0] cd,
                                 bit dr, bit dw, logic [31:0] da, logic [31:0] dd);
        c_req[l]   = cr;
        c_we[l]    = cw;
        c_addr[l]  = ca;
        c_wdata[l] = cd;
        d_req[l]   = dr;
        d_we[l]    = dw;
        d_addr[l]  = da;
        d_wdata[l] = dd;
    endtask

    function automatic logic [31:0] expRead(int l, logic [31:0] a);
        bit [33:0] k = {2'(l), a};
        if (shadow.exists(k)) return shadow[k];
        if (a == 32'h40) return 32'hDEADBEEF;
        return 32'h0;
    endfunction

    task automatic resetDut();
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // One isolated transaction; expected timing: gnt/strobe one cycle after req, done 2 (+RD_LAT) later.
    task automatic doTxn(int l, bit is_dma, bit we, logic [31:0] addr, logic [31:0] wdata,
                         logic [31:0] exp_rdata, int pulse_rel, string tag);
        int exp_done = we ? 2 : latOf(l) + 2;
        int gnt_at = -1, gnt_n = 0, en_at = -1, en_n = 0, done_at = -1, done_n = 0;
        int other_gnt = 0, other_done = 0;
        logic mwe = 1'b0;
        logic [31:0] ma = '0, mwd = '0;
        for (int rel = 0; rel <= exp_done + 2; rel++) begin
            step();
            if (is_dma) applyStimulus(l, 1'b0, 1'b0, 32'h0, 32'h0, rel < 2, we, addr, wdata);
            else        applyStimulus(l, rel < 2, we, addr, wdata, rel == pulse_rel, 1'b0, 32'h0, 32'h0);
            settle();
            if (is_dma ? d_gnt_v[l] : c_gnt_v[l]) begin
                gnt_n++;
                if (gnt_at < 0) gnt_at = rel;
            end
            if (mem_en_v[l]) begin
                en_n++;
                if (en_at < 0) en_at = rel;
                mwe = mem_we_v[l];
                ma  = mem_addr_v[l];
                mwd = mem_wdata_v[l];
            end
            if (is_dma ? d_done_v[l] : c_done_v[l]) begin
                done_n++;
                if (done_at < 0) done_at = rel;
            end
            other_gnt  += int'(is_dma ? c_gnt_v[l] : d_gnt_v[l]);
            other_done += int'(is_dma ? c_done_v[l] : d_done_v[l]);
            checkOutput({tag, "_stall"}, stall_v[l], !is_dma && rel < exp_done);
        end
        checkOutput({tag, "_gnt_at"}, gnt_at, 1);
        checkOutput({tag, "_gnt_n"}, gnt_n, 1);
        checkOutput({tag, "_en_at"}, en_at, 1);
        checkOutput({tag, "_en_n"}, en_n, 1);
        checkOutput({tag, "_mem_we"}, mwe, we);
        checkOutput({tag, "_mem_addr"}, ma, addr);
        if (we) checkOutput({tag, "_mem_wdata"}, mwd, wdata);
        checkOutput({tag, "_done_at"}, done_at, exp_done);
        checkOutput({tag, "_done_n"}, done_n, 1);
        checkOutput({tag, "_other_gnt"}, other_gnt, 0);
        checkOutput({tag, "_other_done"}, other_done, 0);
        if (!we) checkOutput({tag, "_rdata"}, is_dma ? d_rdata_v[l] : c_rdata_v[l], exp_rdata);
        if (we) shadow[{2'(l), addr}] = wdata;
    endtask

    // Both requesters contend repeatedly: core reads 0x40, DMA writes 0x200; grants must alternate.
    task automatic arbSeq(int l, int n_each, string tag);
        bit      rq[2];
        bit      busy[2];
        bit      drop[2];
        int      rem[2];
        int      ready[2];
        req_id_t order[$];
        req_id_t mlast = REQ_DMA;
        req_id_t r;
        bit      prev_both = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rq[i] = 1'b0; busy[i] = 1'b0; drop[i] = 1'b0;
            rem[i] = n_each; ready[i] = cyc;
        end
        for (int k = 0; k < 400; k++) begin
            if (rem[0] == 0 && rem[1] == 0) break;
            step();
            for (int i = 0; i < 2; i++) begin
                if (drop[i]) begin rq[i] = 1'b0; drop[i] = 1'b0; end
                if (!busy[i] && rem[i] > 0 && cyc >= ready[i]) begin rq[i] = 1'b1; busy[i] = 1'b1; end
            end
            applyStimulus(l, rq[0], 1'b0, 32'h40, 32'h0,
                          rq[1], 1'b1, 32'h200, 32'hC0DE0000 + 32'(rem[1]));
            settle();
            if (c_gnt_v[l] || d_gnt_v[l]) begin
                checkOutput({tag, "_dual_gnt"}, c_gnt_v[l] & d_gnt_v[l], 1'b0);
                r = d_gnt_v[l] ? REQ_DMA : REQ_CORE;
                if (prev_both) checkOutput({tag, "_rr"}, r, (mlast == REQ_CORE) ? REQ_DMA : REQ_CORE);
                mlast = r;
                order.push_back(r);
                drop[r] = 1'b1;
                if (r == REQ_DMA) shadow[{2'(l), 32'h200}] = 32'hC0DE0000 + 32'(rem[1]);
            end
            if (c_done_v[l]) begin busy[0] = 1'b0; ready[0] = cyc + 1; rem[0]--; end
            if (d_done_v[l]) begin busy[1] = 1'b0; ready[1] = cyc + 1; rem[1]--; end
            prev_both = rq[0] & rq[1];
        end
        checkOutput({tag, "_complete"}, rem[0] + rem[1], 0);
        checkOutput({tag, "_count"}, order.size(), 2 * n_each);
        foreach (order[i]) checkOutput({tag, "_order"}, order[i], (i % 2) ? REQ_DMA : REQ_CORE);
        checkOutput({tag, "_rdata"}, c_rdata_v[l], expRead(l, 32'h40));
        step();
        applyStimulus(l, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        int dn;
        int l;
        bit is_dma, we;
        logic [31:0] a, wd;

        for (int i = 0; i < NL; i++) applyStimulus(i, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        step(); step(); step();
        settle();
        checkOutput("reset_flags", {c_gnt_v[0], d_gnt_v[0], c_done_v[0], d_done_v[0], mem_en_v[0], mem_we_v[0]}, '0);
        checkOutput("reset_stall", stall_v, '0);
        checkOutput("reset_rdata", {c_rdata_v[0], d_rdata_v[0]}, '0);
        step();
        rst = 1'b0;

        doTxn(0, 1'b0, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, -1, "core_rd");
        doTxn(0, 1'b1, 1'b1, 32'h80, 32'h12345678, 32'h0, -1, "dma_wr");
        doTxn(0, 1'b0, 1'b0, 32'h80, 32'h0, 32'h12345678, -1, "core_rd80");

        resetDut();
        arbSeq(0, 2, "arb");

        // Abort a DMA read in WAIT with an asynchronous reset.
        step();
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0);
        step();
        step();
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        settle();
        checkOutput("rst_wait_flags", {c_gnt_v[0], d_gnt_v[0], c_done_v[0], d_done_v[0], mem_en_v[0], mem_we_v[0], stall_v[0]}, '0);
        checkOutput("rst_wait_addr", {mem_addr_v[0], mem_wdata_v[0]}, '0);
        checkOutput("rst_wait_rdata", {c_rdata_v[0], d_rdata_v[0]}, '0);
        step();
        step();
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            settle();
            dn += int'(d_done_v[0]) + int'(d_gnt_v[0]);
        end
        checkOutput("rst_no_done", dn, 0);
        arbSeq(0, 1, "post_rst");

        for (int i = 1; i < NL; i++) begin
            doTxn(i, 1'b1, 1'b1, 32'h300, 32'hA5A50000 + 32'(i), 32'h0, -1, "sweep_wr");
            doTxn(i, 1'b0, 1'b0, 32'h300, 32'h0, expRead(i, 32'h300), -1, "sweep_rd");
            doTxn(i, 1'b1, 1'b0, 32'h40, 32'h0, expRead(i, 32'h40), -1, "sweep_drd");
        end

        for (int i = 0; i < 12; i++) begin
            l      = int'($urandom_range(0, NL - 1));
            is_dma = 1'($urandom_range(0, 1));
            we     = 1'($urandom_range(0, 1));
            a      = 32'($urandom_range(0, 7)) << 4;
            wd     = $urandom;
            doTxn(l, is_dma, we, a, wd, expRead(l, a), -1, "rand");
        end

        doTxn(0, 1'b0, 1'b0, 32'h80, 32'h0, expRead(0, 32'h80), 2, "pulse");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
